// File: rtl/alu_reg8_pkg.sv
// Shared constants for the registered 8-bit add/subtract unit:
// datapath width and the MODO operation encodings.
package alu_reg8_pkg;

    localparam int W = 8;

    typedef enum logic [1:0] {
        MODO_HOLD  = 2'b00,
        MODO_SUMA  = 2'b01,
        MODO_RESTA = 2'b10,
        MODO_CLR   = 2'b11
    } modo_t;

endpackage

// File: rtl/alu_reg8_if.sv
// Operand/result bundle between the stimulus generator (master) and
// the ALU (slave).
interface alu_reg8_if;
    import alu_reg8_pkg::*;

    logic         enb;
    logic [1:0]   modo;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rci;
    logic [W-1:0] q;
    logic         rco;

    modport master (
        output enb, modo, a, b, rci,
        input  q, rco
    );

    modport slave (
        input  enb, modo, a, b, rci,
        output q, rco
    );

endinterface

// File: rtl/alu_reg8_sumador4.sv
// 4-bit ripple-carry adder; two of these are chained to form the
// 8-bit datapath.
module sumador4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/alu_reg8.sv
// Registered 8-bit add/subtract unit with ripple carry/borrow chaining,
// hold/clear modes and a global enable.
module alu_reg8 (
    input  logic      clk,
    input  logic      rst_n,
    alu_reg8_if.slave bus
);
    import alu_reg8_pkg::*;

    logic         resta;
    logic [W-1:0] b_op;
    logic         cin;
    logic         c_mid;
    logic         c_out;
    logic [W-1:0] suma;
    logic [W-1:0] q_reg;
    logic         rco_reg;
    logic [W-1:0] q_next;
    logic         rco_next;

    // Subtract reuses the adder: A + ~B + ~RCI, with borrow = ~carry-out.
    assign resta = (bus.modo == MODO_RESTA);
    assign b_op  = resta ? ~bus.b : bus.b;
    assign cin   = resta ? ~bus.rci : bus.rci;

    sumador4 u_lo (
        .a    (bus.a[3:0]),
        .b    (b_op[3:0]),
        .cin  (cin),
        .s    (suma[3:0]),
        .cout (c_mid)
    );

    sumador4 u_hi (
        .a    (bus.a[7:4]),
        .b    (b_op[7:4]),
        .cin  (c_mid),
        .s    (suma[7:4]),
        .cout (c_out)
    );

    always_comb begin
        q_next   = q_reg;
        rco_next = rco_reg;
        if (bus.enb) begin
            case (modo_t'(bus.modo))
                MODO_HOLD: begin
                    q_next   = q_reg;
                    rco_next = rco_reg;
                end
                MODO_SUMA: begin
                    q_next   = suma;
                    rco_next = c_out;
                end
                MODO_RESTA: begin
                    q_next   = suma;
                    rco_next = ~c_out;
                end
                MODO_CLR: begin
                    q_next   = '0;
                    rco_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            rco_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            rco_reg <= rco_next;
        end
    end

    assign bus.q   = q_reg;
    assign bus.rco = rco_reg;

endmodule

// File: tb/tb_alu_reg8.sv
// Directed bench for alu_reg8: add/sub/hold/clear, enable gating,
// async reset and a two-stage 16-bit cascade.
module tb_alu_reg8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    alu_reg8_if bus ();
    alu_reg8_if lo_bus ();
    alu_reg8_if hi_bus ();

    assign hi_bus.rci = lo_bus.rco;

    alu_reg8 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_reg8 u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lo_bus)
    );

    alu_reg8 u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic enb, input logic [1:0] modo,
                                  input logic [7:0] a, input logic [7:0] b,
                                  input logic rci);
        @(negedge clk);
        bus.enb  = enb;
        bus.modo = modo;
        bus.a    = a;
        bus.b    = b;
        bus.rci  = rci;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] exp_q,
                                input logic exp_rco);
        n_vec++;
        assert (bus.q === exp_q) else begin
            n_fail++;
            $error("[TB] FAIL %s q: observed %0d expected %0d", tag, bus.q, exp_q);
        end
        n_vec++;
        assert (bus.rco === exp_rco) else begin
            n_fail++;
            $error("[TB] FAIL %s rco: observed %0b expected %0b", tag, bus.rco, exp_rco);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        bus.enb = 1'b0; bus.modo = 2'b00; bus.a = '0; bus.b = '0; bus.rci = 1'b0;
        lo_bus.enb = 1'b0; lo_bus.modo = 2'b00; lo_bus.a = '0; lo_bus.b = '0; lo_bus.rci = 1'b0;
        hi_bus.enb = 1'b0; hi_bus.modo = 2'b00; hi_bus.a = '0; hi_bus.b = '0;

        #2 rst_n = 1'b0;
        #1;
        check_output("reset", 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add, carry-out and carry-in
        apply_stimulus(1'b1, 2'b01, 8'd17, 8'd3, 1'b0);
        check_output("add_17_3", 8'd20, 1'b0);
        apply_stimulus(1'b1, 2'b01, 8'd255, 8'd1, 1'b0);
        check_output("add_255_1", 8'd0, 1'b1);
        apply_stimulus(1'b1, 2'b01, 8'd7, 8'd2, 1'b1);
        check_output("add_7_2_ci", 8'd10, 1'b0);
        apply_stimulus(1'b1, 2'b01, 8'd255, 8'd0, 1'b1);
        check_output("add_255_0_ci", 8'd0, 1'b1);

        // Clear then subtract
        apply_stimulus(1'b1, 2'b11, 8'd99, 8'd99, 1'b1);
        check_output("clear", 8'd0, 1'b0);
        apply_stimulus(1'b1, 2'b10, 8'd4, 8'd3, 1'b0);
        check_output("sub_4_3", 8'd1, 1'b0);
        apply_stimulus(1'b1, 2'b10, 8'd15, 8'd1, 1'b0);
        check_output("sub_15_1", 8'd14, 1'b0);
        apply_stimulus(1'b1, 2'b10, 8'd3, 8'd8, 1'b0);
        check_output("sub_3_8", 8'd251, 1'b1);
        apply_stimulus(1'b1, 2'b10, 8'd5, 8'd5, 1'b1);
        check_output("sub_5_5_bi", 8'd255, 1'b1);
        apply_stimulus(1'b1, 2'b10, 8'd9, 8'd5, 1'b1);
        check_output("sub_9_5_bi", 8'd3, 1'b0);

        // Hold on MODO=00 with operands changing
        apply_stimulus(1'b1, 2'b01, 8'd5, 8'd3, 1'b0);
        check_output("add_5_3", 8'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 2'b00, 8'($urandom), 8'($urandom), 1'($urandom));
            check_output("hold_modo", 8'd8, 1'b0);
        end

        // Hold on ENB=0, including a pending clear and a set borrow
        apply_stimulus(1'b1, 2'b10, 8'd3, 8'd1, 1'b0);
        check_output("sub_3_1", 8'd2, 1'b0);
        apply_stimulus(1'b0, 2'b11, 8'hAA, 8'h55, 1'b0);
        check_output("enb0_clr_1", 8'd2, 1'b0);
        apply_stimulus(1'b0, 2'b11, 8'h55, 8'hAA, 1'b1);
        check_output("enb0_clr_2", 8'd2, 1'b0);
        apply_stimulus(1'b0, 2'b01, 8'hFF, 8'hFF, 1'b1);
        check_output("enb0_add", 8'd2, 1'b0);
        apply_stimulus(1'b1, 2'b11, 8'h55, 8'hAA, 1'b1);
        check_output("enb1_clr", 8'd0, 1'b0);
        apply_stimulus(1'b1, 2'b10, 8'd0, 8'd1, 1'b0);
        check_output("sub_0_1", 8'd255, 1'b1);
        apply_stimulus(1'b0, 2'b11, 8'd0, 8'd0, 1'b0);
        check_output("enb0_keep_rco", 8'd255, 1'b1);

        // 16-bit cascade: 0x00FF + 0x0001, operands held two cycles
        @(negedge clk);
        lo_bus.enb = 1'b1; lo_bus.modo = 2'b01; lo_bus.a = 8'hFF; lo_bus.b = 8'h01; lo_bus.rci = 1'b0;
        hi_bus.enb = 1'b1; hi_bus.modo = 2'b01; hi_bus.a = 8'h00; hi_bus.b = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        assert ({lo_bus.rco, lo_bus.q} === 9'h100) else begin
            n_fail++;
            $error("[TB] FAIL casc_lo: observed %h expected %h", {lo_bus.rco, lo_bus.q}, 9'h100);
        end
        @(posedge clk);
        #1;
        n_vec++;
        assert ({hi_bus.q, lo_bus.q} === 16'h0100) else begin
            n_fail++;
            $error("[TB] FAIL casc_16: observed %h expected %h", {hi_bus.q, lo_bus.q}, 16'h0100);
        end
        n_vec++;
        assert (hi_bus.rco === 1'b0) else begin
            n_fail++;
            $error("[TB] FAIL casc_rco_hi: observed %b expected %b", hi_bus.rco, 1'b0);
        end
        lo_bus.enb = 1'b0;
        hi_bus.enb = 1'b0;

        // Asynchronous reset between edges, then first edge operates
        apply_stimulus(1'b1, 2'b01, 8'd100, 8'd100, 1'b0);
        check_output("add_100_100", 8'd200, 1'b0);
        @(negedge clk);
        bus.enb = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset", 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.enb = 1'b1; bus.modo = 2'b01; bus.a = 8'd1; bus.b = 8'd1; bus.rci = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_reset_add", 8'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
